// File: rtl/nq_pkg.sv
// Shared constants and helpers for the instruction prefetch queue.
package nq_pkg;

    localparam int INST_W_DEF = 16;
    localparam logic [INST_W_DEF-1:0] NOP_DEF = 16'h0000;
    localparam int MAX_SLOTS = 8;

    // Extract slot k (slot0 in the low bits) from a packed fetch word of default instruction width.
    function automatic logic [INST_W_DEF-1:0] slot(input logic [INST_W_DEF*MAX_SLOTS-1:0] word,
                                                   input int unsigned k);
        return word[k*INST_W_DEF +: INST_W_DEF];
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side and issue-side signals of the prefetch queue.
// slave = the queue, master = the surrounding fetch/decode logic.
interface inst_prefetch_queue_if #(
    parameter int INST_W = 16,
    parameter int SLOTS  = 2,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      fetch_valid;
    logic [INST_W*SLOTS-1:0]   fetch_word;
    logic                      fetch_ready;
    logic                      stall;
    logic                      flush;
    logic [INST_W-1:0]         inst_out;
    logic                      inst_valid;
    logic [CNT_W-1:0]          count;

    modport master (
        output fetch_valid, fetch_word, stall, flush,
        input  fetch_ready, inst_out, inst_valid, count
    );

    modport slave (
        input  fetch_valid, fetch_word, stall, flush,
        output fetch_ready, inst_out, inst_valid, count
    );

endinterface

// File: rtl/inst_prefetch_store.sv
// DEPTH x INST_W instruction storage with a multi-slot write port and one read port.
// wr_skip0 drops slot0 of the word and packs slots 1..SLOTS-1 starting at wr_ptr.
module inst_prefetch_store #(
    parameter int INST_W = 16,
    parameter int SLOTS  = 2,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    wr_skip0,
    input  logic [PTR_W-1:0]        wr_ptr,
    input  logic [INST_W*SLOTS-1:0] wr_word,
    input  logic [PTR_W-1:0]        rd_ptr,
    output logic [INST_W-1:0]       rd_data
);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] mem_d [DEPTH];

    function automatic int wr_index(input logic [PTR_W-1:0] base, input int k, input logic skip);
        return (int'(base) + k - (skip ? 1 : 0)) % DEPTH;
    endfunction

    // Scatter the accepted slots into consecutive (wrapping) entries.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (!(wr_skip0 && k == 0)) begin
                    mem_d[wr_index(wr_ptr, k, wr_skip0)] = wr_word[k*INST_W +: INST_W];
                end
            end
        end
    end

    // Data entries carry no reset; validity is tracked by the queue's count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: accepts SLOTS-wide fetch words, issues one instruction per cycle,
// lowest slot first, with decode stall, flush and fetch backpressure.
// Optional build macro: PREFETCH_BYPASS_EN -- an empty queue forwards fetch slot0 to inst_out
// in the same cycle.
module inst_prefetch_queue
    import nq_pkg::*;
#(
    parameter int                 INST_W   = INST_W_DEF,
    parameter int                 SLOTS    = 2,
    parameter int                 DEPTH    = 4,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_prefetch_queue_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              head_valid;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              wr_skip0;
    int                n_wr;
    logic [INST_W-1:0] rd_data;

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] ptr, input int n);
        return PTR_W'((int'(ptr) + n) % DEPTH);
    endfunction

    // Readiness only looks at the registered occupancy, so fetch never sees a loop through valid.
    assign bus.fetch_ready = (DEPTH - int'(count_q)) >= SLOTS;
    assign head_valid      = (count_q != '0);

    // Bypass applies only when nothing is queued and fetch has a live word.
    always_comb begin
        bypass = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        bypass = !head_valid && bus.fetch_valid && !bus.flush;
`endif
    end

    assign bus.inst_valid = head_valid || bypass;
    assign bus.inst_out   = bypass     ? bus.fetch_word[INST_W-1:0] :
                            head_valid ? rd_data : NOP_INST;

    // Next-state for pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        push     = bus.fetch_valid && bus.fetch_ready && !bus.flush;
        pop      = head_valid && !bus.stall && !bus.flush;
        wr_skip0 = bypass && !bus.stall;
        n_wr     = push ? (SLOTS - (wr_skip0 ? 1 : 0)) : 0;
        rd_ptr_d = pop  ? ptr_adv(rd_ptr_q, 1) : rd_ptr_q;
        wr_ptr_d = ptr_adv(wr_ptr_q, n_wr);
        count_d  = CNT_W'(int'(count_q) + n_wr - (pop ? 1 : 0));
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.count = count_q;

    inst_prefetch_store #(
        .INST_W (INST_W),
        .SLOTS  (SLOTS),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_store (
        .clk      (clk),
        .wr_en    (push && rst),
        .wr_skip0 (wr_skip0),
        .wr_ptr   (wr_ptr_q),
        .wr_word  (bus.fetch_word),
        .rd_ptr   (rd_ptr_q),
        .rd_data  (rd_data)
    );

    // Occupancy must stay within 0..DEPTH and never pop an empty queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (int'(count_q) <= DEPTH);
            assert (!(pop && !head_valid));
        end
    end

endmodule
